// File: rtl/mux_ctrl_if.sv
// Bus bundle between the host/config logic, the mux controller and the project mux.
// The master modport is the controller's view; slave is the host-plus-mux side.
interface mux_ctrl_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned IW_W   = 18,
   parameter int unsigned OW_W   = 24
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [IW_W-1:0]   req_iw;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [OW_W-1:0]   rsp_ow;
   logic              rsp_err;
   logic [ADDR_W-1:0] mux_addr;
   logic [IW_W-1:0]   mux_iw;
   logic [OW_W-1:0]   mux_ow;
   logic [ADDR_W-1:0] cur_addr;
   logic              busy;

   modport master (
      input  req_valid, req_addr, req_iw, rsp_ready, mux_ow,
      output req_ready, rsp_valid, rsp_ow, rsp_err, mux_addr, mux_iw, cur_addr, busy
   );

   modport slave (
      output req_valid, req_addr, req_iw, rsp_ready, mux_ow,
      input  req_ready, rsp_valid, rsp_ow, rsp_err, mux_addr, mux_iw, cur_addr, busy
   );
endinterface

// File: rtl/mux_ctrl.sv
// Initiator side of the project-select mux: break-before-make switching (park on an
// unused address with a zeroed input word), settle window, then capture of the output word.
module mux_ctrl #(
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned IW_W       = 18,
   parameter int unsigned OW_W       = 24,
   parameter int unsigned NUM_PROJ   = 23,
   parameter int unsigned IDLE_ADDR  = 31,
   parameter int unsigned GUARD_CYC  = 2,
   parameter int unsigned SETTLE_CYC = 4
) (
   input logic        clk,
   input logic        rst,
   mux_ctrl_if.master bus
);

   localparam int unsigned CNT_MAX = (GUARD_CYC > SETTLE_CYC) ? GUARD_CYC : SETTLE_CYC;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [ADDR_W-1:0] PARK_ADDR  = ADDR_W'(IDLE_ADDR);
   localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(GUARD_CYC - 1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PARK,
      S_SETTLE,
      S_RESP
   } state_t;

   state_t            state_q,     state_n;
   logic [CNT_W-1:0]  cnt_q,       cnt_n;
   logic [ADDR_W-1:0] lat_addr_q,  lat_addr_n;
   logic [IW_W-1:0]   lat_iw_q,    lat_iw_n;
   logic [ADDR_W-1:0] mux_addr_q,  mux_addr_n;
   logic [IW_W-1:0]   mux_iw_q,    mux_iw_n;
   logic [ADDR_W-1:0] cur_addr_q,  cur_addr_n;
   logic              rsp_valid_q, rsp_valid_n;
   logic [OW_W-1:0]   rsp_ow_q,    rsp_ow_n;
   logic              rsp_err_q,   rsp_err_n;
   logic              req_ready_q, req_ready_n;
   logic              busy_q,      busy_n;

   logic req_unpop_c;
   logic req_same_c;

   assign req_unpop_c = (32'(bus.req_addr) >= NUM_PROJ);
   assign req_same_c  = (bus.req_addr == cur_addr_q);

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         lat_addr_q  <= PARK_ADDR;
         lat_iw_q    <= '0;
         mux_addr_q  <= PARK_ADDR;
         mux_iw_q    <= '0;
         cur_addr_q  <= PARK_ADDR;
         rsp_valid_q <= 1'b0;
         rsp_ow_q    <= '0;
         rsp_err_q   <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_n;
         cnt_q       <= cnt_n;
         lat_addr_q  <= lat_addr_n;
         lat_iw_q    <= lat_iw_n;
         mux_addr_q  <= mux_addr_n;
         mux_iw_q    <= mux_iw_n;
         cur_addr_q  <= cur_addr_n;
         rsp_valid_q <= rsp_valid_n;
         rsp_ow_q    <= rsp_ow_n;
         rsp_err_q   <= rsp_err_n;
         req_ready_q <= req_ready_n;
         busy_q      <= busy_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state_q;
      cnt_n       = cnt_q;
      lat_addr_n  = lat_addr_q;
      lat_iw_n    = lat_iw_q;
      mux_addr_n  = mux_addr_q;
      mux_iw_n    = mux_iw_q;
      cur_addr_n  = cur_addr_q;
      rsp_valid_n = rsp_valid_q;
      rsp_ow_n    = rsp_ow_q;
      rsp_err_n   = rsp_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               lat_addr_n = bus.req_addr;
               lat_iw_n   = bus.req_iw;
               cnt_n      = '0;
               if (req_unpop_c) begin
                  rsp_valid_n = 1'b1;
                  rsp_err_n   = 1'b1;
                  rsp_ow_n    = '0;
                  state_n     = S_RESP;
               end else if (req_same_c) begin
                  // Target already enabled: only the input word changes, no park needed
                  mux_iw_n = bus.req_iw;
                  state_n  = S_SETTLE;
               end else begin
                  mux_addr_n = PARK_ADDR;
                  mux_iw_n   = '0;
                  cur_addr_n = PARK_ADDR;
                  state_n    = S_PARK;
               end
            end
         end

         S_PARK: begin
            if (cnt_q == GUARD_LAST) begin
               mux_addr_n = lat_addr_q;
               mux_iw_n   = lat_iw_q;
               cur_addr_n = lat_addr_q;
               cnt_n      = '0;
               state_n    = S_SETTLE;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end

         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               rsp_ow_n    = bus.mux_ow;
               rsp_err_n   = 1'b0;
               rsp_valid_n = 1'b1;
               state_n     = S_RESP;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end

         S_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_n = 1'b0;
               state_n     = S_IDLE;
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      req_ready_n = (state_n == S_IDLE);
      busy_n      = (state_n != S_IDLE);
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_ow    = rsp_ow_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.mux_addr  = mux_addr_q;
   assign bus.mux_iw    = mux_iw_q;
   assign bus.cur_addr  = cur_addr_q;
   assign bus.busy      = busy_q;

   // Two populated projects must never be enabled back to back
   a_break_before_make : assert property (
      @(posedge clk) disable iff (rst)
      (mux_addr_q != $past(mux_addr_q)) |->
         ((32'(mux_addr_q) >= NUM_PROJ) || (32'($past(mux_addr_q)) >= NUM_PROJ))
   );

   a_rsp_hold : assert property (
      @(posedge clk) disable iff (rst)
      (rsp_valid_q && !bus.rsp_ready) |=>
         (rsp_valid_q && $stable(rsp_ow_q) && $stable(rsp_err_q))
   );

endmodule

// File: tb/tb_mux_ctrl.sv
// Randomized scoreboard bench for mux_ctrl; a behavioural model predicts each response
// and the mux switching sequence, a monitor pops and compares whenever rsp_valid rises.
module tb_mux_ctrl;

   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned IW_W     = 18;
   localparam int unsigned OW_W     = 24;
   localparam int unsigned NUM_PROJ = 23;
   localparam int unsigned IDLE_A   = 31;
   localparam int unsigned GUARD    = 2;
   localparam int unsigned SETTLE   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mux_ctrl_if #(.ADDR_W(ADDR_W), .IW_W(IW_W), .OW_W(OW_W)) bus ();

   mux_ctrl #(
      .ADDR_W(ADDR_W), .IW_W(IW_W), .OW_W(OW_W), .NUM_PROJ(NUM_PROJ),
      .IDLE_ADDR(IDLE_A), .GUARD_CYC(GUARD), .SETTLE_CYC(SETTLE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Project model: each populated slot returns its own address mixed with its input word
   function automatic logic [OW_W-1:0] ow_fn(input logic [ADDR_W-1:0] a, input logic [IW_W-1:0] iw);
      if (32'(a) >= NUM_PROJ) return '0;
      return {1'b1, a, iw ^ 18'h2C3A1};
   endfunction

   assign bus.mux_ow = ow_fn(bus.mux_addr, bus.mux_iw);

   typedef struct {
      logic [OW_W-1:0] ow;
      logic            err;
      int unsigned     lat;
      int unsigned     acc;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   logic [ADDR_W-1:0] m_addr = ADDR_W'(IDLE_A);
   logic [IW_W-1:0]   m_iw   = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Response monitor: pops on each new response, then checks it holds while stalled
   logic prev_v = 1'b0;
   exp_t cur_e;
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (bus.rsp_valid && !prev_v) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
               cur_e = sb.pop_front();
               chk("rsp_ow", 32'(bus.rsp_ow), 32'(cur_e.ow));
               chk("rsp_err", 32'(bus.rsp_err), 32'(cur_e.err));
               chk("latency", cyc - cur_e.acc, cur_e.lat);
            end
         end else if (bus.rsp_valid && prev_v) begin
            chk("rsp_ow_hold", 32'(bus.rsp_ow), 32'(cur_e.ow));
            chk("rsp_err_hold", 32'(bus.rsp_err), 32'(cur_e.err));
            chk("ready_in_resp", 32'(bus.req_ready), 32'd0);
         end
         prev_v = bus.rsp_valid;
      end
   end

   // Mux address watcher: every change must pass through an unpopulated address
   logic [ADDR_W-1:0] prev_ma = ADDR_W'(IDLE_A);
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mux_addr != prev_ma)
            chk("break_before_make",
                32'((32'(prev_ma) < NUM_PROJ) && (32'(bus.mux_addr) < NUM_PROJ)), 32'd0);
         chk("busy_vs_ready", 32'(bus.busy), 32'(!bus.req_ready));
      end
      prev_ma = bus.mux_addr;
   end

   task automatic scramble(input logic noise);
      bus.req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.req_addr  = ADDR_W'($urandom);
      bus.req_iw    = IW_W'($urandom);
   endtask

   task automatic wait_ready(output logic ok);
      int w = 0;
      while (!bus.req_ready && w < 60) begin
         @(negedge clk);
         w++;
      end
      ok = bus.req_ready;
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   // One host transaction; called and returning at a negedge
   task automatic do_req(input logic [ADDR_W-1:0] a, input logic [IW_W-1:0] iw,
                         input int stall, input logic noise);
      exp_t e;
      logic ok;
      logic err, same;
      int   w;
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_iw    = iw;
      wait_ready(ok);
      if (!ok) begin
         bus.req_valid = 1'b0;
         return;
      end
      err   = (32'(a) >= NUM_PROJ);
      same  = !err && (a == m_addr);
      e.ow  = err ? '0 : ow_fn(a, iw);
      e.err = err;
      e.lat = err ? 0 : (same ? SETTLE : GUARD + SETTLE);
      e.acc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      if (err) begin
         chk("err_mux_addr", 32'(bus.mux_addr), 32'(m_addr));
         chk("err_mux_iw", 32'(bus.mux_iw), 32'(m_iw));
         chk("err_cur_addr", 32'(bus.cur_addr), 32'(m_addr));
      end else if (same) begin
         chk("same_mux_addr", 32'(bus.mux_addr), 32'(a));
         chk("same_mux_iw", 32'(bus.mux_iw), 32'(iw));
      end else begin
         for (int k = 0; k < int'(GUARD); k++) begin
            chk("park_addr", 32'(bus.mux_addr), IDLE_A);
            chk("park_iw", 32'(bus.mux_iw), 32'd0);
            chk("park_cur", 32'(bus.cur_addr), IDLE_A);
            scramble(noise);
            @(negedge clk);
         end
         chk("sel_addr", 32'(bus.mux_addr), 32'(a));
         chk("sel_iw", 32'(bus.mux_iw), 32'(iw));
         chk("sel_cur", 32'(bus.cur_addr), 32'(a));
      end
      if (!err) begin
         m_addr = a;
         m_iw   = iw;
      end
      w = 0;
      while (!bus.rsp_valid && w < 60) begin
         scramble(noise);
         @(negedge clk);
         w++;
      end
      if (!bus.rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
      for (int s = 0; s < stall; s++) begin
         scramble(noise);
         chk("stall_ready", 32'(bus.req_ready), 32'd0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      chk("hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("hs_req_ready", 32'(bus.req_ready), 32'd1);
   endtask

   // Reset asserted mid-SETTLE must clear the mux drive at once and drop the response
   task automatic reset_in_settle(input logic [ADDR_W-1:0] a);
      logic ok;
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_iw    = IW_W'($urandom);
      wait_ready(ok);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (GUARD + 1) @(negedge clk);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mux_addr", 32'(bus.mux_addr), IDLE_A);
      chk("rst_mux_iw", 32'(bus.mux_iw), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_cur_addr", 32'(bus.cur_addr), IDLE_A);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      sb.delete();
      @(negedge clk);
      rst    = 1'b0;
      m_addr = ADDR_W'(IDLE_A);
      m_iw   = '0;
      repeat (12) @(negedge clk);
      chk("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_iw    = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_mux_addr", 32'(bus.mux_addr), IDLE_A);
      chk("reset_cur_addr", 32'(bus.cur_addr), IDLE_A);
      chk("reset_mux_iw", 32'(bus.mux_iw), 32'd0);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_ow", 32'(bus.rsp_ow), 32'd0);
      chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
      chk("reset_busy", 32'(bus.busy), 32'd0);

      do_req(5'd5, 18'h2A5A5, 0, 1'b0);
      do_req(5'd5, 18'h00001, 0, 1'b0);
      do_req(5'd23, 18'h3FFFF, 0, 1'b0);
      do_req(5'd31, 18'h12345, 0, 1'b0);
      do_req(5'd22, 18'h0ABCD, 10, 1'b1);
      do_req(5'd0, 18'h11111, 1, 1'b1);
      do_req(5'd22, 18'h22222, 0, 1'b1);
      do_req(5'd7, 18'h33333, 2, 1'b1);
      reset_in_settle(5'd9);

      for (int i = 0; i < 150; i++) begin
         logic [ADDR_W-1:0] a;
         a = ($urandom_range(0, 3) == 0) ? m_addr : ADDR_W'($urandom_range(0, 31));
         do_req(a, IW_W'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
